aes_inv_rcon: RTL

AES_INV_RCON -- requirements
Module: aes_inv_rcon

---
 rtl/aes_inv_rcon.sv | 81 ++++++++
 1 files changed

// File: rtl/aes_inv_rcon.sv
// Reverse AES round-constant sequencer: walks rcon backwards from the key
// schedule's last constant down to 0x01, one step per next request.
//
// state  | meaning
// IDLE   | no sequence loaded, outputs at reset values
// ACTIVE | rcon/round hold a legal sequence value
// DONE   | stepped past 0x01, waiting for init
module aes_inv_rcon #(
  parameter bit ALLOW_RESTART = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keylen,
  input  logic       init,
  input  logic       next,
  output logic [7:0] rcon,
  output logic [3:0] round,
  output logic       valid,
  output logic       last,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  round_q, round_d;
  logic        init_acc;

  // GF(2^8) division by x modulo 0x11B
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    if (x[0]) inv_xtime = ((x ^ 8'h1B) >> 1) | 8'h80;
    else      inv_xtime = x >> 1;
  endfunction

  assign init_acc = init && (ALLOW_RESTART || (state_q != ACTIVE));

  always_comb begin
    state_d = state_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    if (init_acc) begin
      state_d = ACTIVE;
      rcon_d  = keylen ? 8'h40 : 8'h36;
      round_d = keylen ? 4'd6 : 4'd9;
    end else if ((state_q == ACTIVE) && next) begin
      if (round_q != 4'd0) begin
        rcon_d  = inv_xtime(rcon_q);
        round_d = round_q - 4'd1;
      end else begin
        // stop before the 0x8D wrap value ever reaches the output
        state_d = DONE;
        rcon_d  = 8'h00;
        round_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rcon_q  <= 8'h00;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
    end
  end

  assign rcon  = rcon_q;
  assign round = round_q;
  assign valid = (state_q == ACTIVE);
  assign last  = (state_q == ACTIVE) && (round_q == 4'd0);
  assign done  = (state_q == DONE);

endmodule
